qdma_dsc_out_crd_arb: RTL

Parametrised multi-channel descriptor-out stage with credit-based flow control. Accepts descriptors from NUM_CH independent sources (valid/ready), buffers them per channel, and issues them one per cycle onto a single descriptor-out link. Each channel is gated by its own sink-returned credit count. It sits between per-queue descriptor engines and the PCIe-side descriptor consumer, generalising the single-channel dsc/crd pairing to N channels with buffering and fair arbitration.

---
 rtl/qdma_dsc_arb_pkg.sv | 40 ++++
 rtl/qdma_dsc_ch_fifo.sv | 54 +++++
 rtl/qdma_dsc_out_crd_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/qdma_dsc_arb_pkg.sv
// Shared types and the round-robin pick function for the multi-channel
// descriptor-out credit arbiter.
package qdma_dsc_arb_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CH_W  = 4;
    localparam int CRD_W_DEF = 8;

    typedef logic [MAX_CH_W-1:0]  ch_idx_t;
    typedef logic [MAX_CH-1:0]    ch_vec_t;
    typedef logic [CRD_W_DEF-1:0] crd_cnt_t;

    typedef struct packed {
        logic    found;
        ch_idx_t idx;
    } rr_pick_t;

    // First eligible channel at or after ptr, wrapping at num_ch.
    // Scans from the farthest offset down so the nearest match is kept.
    function automatic rr_pick_t rr_pick(input ch_vec_t eligible,
                                         input ch_idx_t ptr,
                                         input int      num_ch);
        rr_pick_t r;
        int       c;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < num_ch) begin
                c = int'(ptr) + k;
                if (c >= num_ch) c = c - num_ch;
                if (eligible[c[MAX_CH_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = ch_idx_t'(c);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qdma_dsc_ch_fifo.sv
// Single-clock per-channel descriptor FIFO with registered full/empty flags;
// a pop in the same cycle frees the slot for a concurrent push.
module qdma_dsc_ch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          wr_en, rd_en;

    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) count_nxt = count + (AW+1)'(1);
        if (rd_en && !wr_en) count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/qdma_dsc_out_crd_arb.sv
// N-channel descriptor-out stage: per-channel FIFOs, sink-returned credits and
// round-robin issue. Define QDMA_DSC_OUT_STATS_EN to add per-channel issue counters.
module qdma_dsc_out_crd_arb
    import qdma_dsc_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DSC_W      = 256,
    parameter int CRD_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           src_vld,
    output logic [NUM_CH-1:0]           src_rdy,
    input  logic [NUM_CH*DSC_W-1:0]     src_dsc,
    input  logic                        crd_vld,
    input  logic [$clog2(NUM_CH)-1:0]   crd_ch,
    input  logic [CRD_W-1:0]            crd_num,
    output logic                        dsc_vld,
    output logic [$clog2(NUM_CH)-1:0]   dsc_ch,
    output logic [DSC_W-1:0]            dsc,
    output logic [NUM_CH-1:0]           crd_ovf
`ifdef QDMA_DSC_OUT_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]        dsc_cnt
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef logic [DSC_W-1:0] dsc_t;
    typedef logic [CRD_W-1:0] crd_t;

    // Source handshake: a descriptor moves when src_vld[i] && src_rdy[i] at a
    // rising edge; src_rdy[i] is the registered not-full of FIFO i. The output
    // side has no ready: a held credit guarantees the sink accepts it.
    logic [NUM_CH-1:0] full, empty, push, pop;
    dsc_t              rd_data [NUM_CH];
    crd_t              cnt [NUM_CH];
    logic [CRD_W:0]    sum [NUM_CH];
    logic [CH_W-1:0]   ptr, gnt_ch;
    logic              gnt_vld;
    ch_vec_t           elig;
    rr_pick_t          pick;
    logic              unused_pick_hi;

    assign src_rdy = ~full;
    assign push    = src_vld & ~full;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        qdma_dsc_ch_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DSC_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .wdata (src_dsc[g*DSC_W +: DSC_W]),
            .rdata (rd_data[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Eligibility uses registered counters only, so returned credits count next cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = ~empty[i] && (cnt[i] != '0);
        end
        pick           = rr_pick(elig, ch_idx_t'(ptr), NUM_CH);
        gnt_vld        = pick.found;
        gnt_ch         = pick.idx[CH_W-1:0];
        unused_pick_hi = ^pick.idx;
        pop            = '0;
        if (gnt_vld) pop[gnt_ch] = 1'b1;
    end

    // Grant only happens with cnt > 0, so the decrement never underflows.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, cnt[i]} - {{CRD_W{1'b0}}, pop[i]};
            if (crd_vld && crd_ch == CH_W'(i)) sum[i] = sum[i] + {1'b0, crd_num};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            crd_ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sum[i][CRD_W]) begin
                    cnt[i]     <= '1;
                    crd_ovf[i] <= 1'b1;
                end else begin
                    cnt[i] <= sum[i][CRD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            dsc_vld <= 1'b0;
            dsc_ch  <= '0;
            dsc     <= '0;
        end else begin
            dsc_vld <= gnt_vld;
            if (gnt_vld) begin
                ptr    <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
                dsc_ch <= gnt_ch;
                dsc    <= rd_data[gnt_ch];
            end
        end
    end

`ifdef QDMA_DSC_OUT_STATS_EN
    logic [31:0] issued [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) issued[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pop[i]) issued[i] <= issued[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) dsc_cnt[i*32 +: 32] = issued[i];
    end
`endif

endmodule
